// File: rtl/hamming_piso_serializer.sv
// Parallel-in/serial-out stage for Hamming codewords: shifts each word out
// LSB first, with a one-word holding buffer so back-to-back words stay contiguous.
module hamming_piso_serializer #(
  parameter int   WIDTH    = 7,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             acc, last, free;

  assign pi_ready = !rst && !hold_full;
  assign acc      = pi_valid && pi_ready;
  assign last     = (state == SHIFT) && (cnt == LAST_CNT);
  assign free     = (state == IDLE) || last;

  // Next-state: a held word always wins the free slot so ordering stays FIFO.
  always_comb begin
    state_nx     = state;
    sreg_nx      = sreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    cnt_nx       = cnt;
    if (free) begin
      if (hold_full) begin
        sreg_nx      = hold;
        hold_full_nx = 1'b0;
        cnt_nx       = ZERO_CNT;
        state_nx     = SHIFT;
      end else if (acc) begin
        sreg_nx  = pi_data;
        cnt_nx   = ZERO_CNT;
        state_nx = SHIFT;
      end else if (last) begin
        state_nx = IDLE;
        cnt_nx   = ZERO_CNT;
      end else begin
        state_nx = state;
      end
    end else begin
      sreg_nx = {IDLE_BIT, sreg[WIDTH-1:1]};
      cnt_nx  = cnt + ONE_CNT;
      if (acc) begin
        hold_nx      = pi_data;
        hold_full_nx = 1'b1;
      end else begin
        hold_full_nx = hold_full;
      end
    end
  end

  // State register; reset discards both the in-flight and the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= {WIDTH{1'b0}};
      hold      <= {WIDTH{1'b0}};
      hold_full <= 1'b0;
      cnt       <= ZERO_CNT;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
      cnt       <= cnt_nx;
    end
  end

  // Serial outputs depend on registered state only.
  always_comb begin
    so       = IDLE_BIT;
    so_valid = 1'b0;
    so_first = 1'b0;
    case (state)
      SHIFT: begin
        so       = sreg[0];
        so_valid = 1'b1;
        so_first = (cnt == ZERO_CNT);
      end
      IDLE: begin
        so       = IDLE_BIT;
        so_valid = 1'b0;
        so_first = 1'b0;
      end
      default: begin
        so       = IDLE_BIT;
        so_valid = 1'b0;
        so_first = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hamming_piso_serializer.sv
// Self-checking bench: a per-cycle timeline of expected serial bits is built
// from accepted words and compared against the serializer every cycle.
module tb_hamming_piso_serializer;

  localparam int   W        = 7;
  localparam logic IDLE_BIT = 1'b0;
  localparam int   MAXC     = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pi_data;
  logic         pi_valid;
  logic         pi_ready;
  logic         so;
  logic         so_valid;
  logic         so_first;

  hamming_piso_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_BIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .pi_data  (pi_data),
    .pi_valid (pi_valid),
    .pi_ready (pi_ready),
    .so       (so),
    .so_valid (so_valid),
    .so_first (so_first)
  );

  always #5 clk = ~clk;

  // Expected line activity per cycle index (cycle t = interval after edge t).
  logic ev [MAXC];
  logic eb [MAXC];
  logic ef [MAXC];
  int   t;
  int   free_at;
  int   hold_rel;
  logic accepted;
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  function automatic logic ready_exp();
    return !rst && !(t < hold_rel);
  endfunction

  // Compare the current cycle, advance the model across the next edge, then clock.
  task automatic tick();
    int e;
    int start;
    #1;
    check("pi_ready", pi_ready, ready_exp());
    check("so_valid", so_valid, ev[t]);
    check("so_first", so_first, ef[t]);
    check("so",       so,       ev[t] ? eb[t] : IDLE_BIT);
    e = t + 1;
    accepted = 1'b0;
    if (rst) begin
      for (int i = e; i < MAXC; i++) begin
        ev[i] = 1'b0;
        eb[i] = 1'b0;
        ef[i] = 1'b0;
      end
      free_at  = e;
      hold_rel = 0;
    end else if (pi_valid && ready_exp()) begin
      accepted = 1'b1;
      start = (free_at > e) ? free_at : e;
      for (int i = 0; i < W; i++) begin
        ev[start+i] = 1'b1;
        eb[start+i] = pi_data[i];
        ef[start+i] = (i == 0);
      end
      free_at = start + W;
      if (start > e) hold_rel = start;
    end
    @(posedge clk);
    #1;
    t = e;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [W-1:0] stream [3];
  int           idx;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 1'b0;
      eb[i] = 1'b0;
      ef[i] = 1'b0;
    end
    free_at  = 0;
    hold_rel = 0;
    t        = 0;

    // Reset gating with a valid word presented throughout.
    rst      = 1'b1;
    pi_valid = 1'b1;
    pi_data  = 7'h55;
    @(posedge clk);
    #1;
    ticks(3);
    rst      = 1'b0;
    pi_valid = 1'b0;
    ticks(3);

    // Single word.
    pi_valid = 1'b1;
    pi_data  = 7'b1011001;
    tick();
    pi_valid = 1'b0;
    ticks(10);

    // Streaming three words with pi_valid held high.
    stream[0] = 7'h01;
    stream[1] = 7'h7E;
    stream[2] = 7'h2A;
    idx = 0;
    for (int n = 0; n < 60 && idx < 3; n++) begin
      pi_valid = 1'b1;
      pi_data  = stream[idx];
      tick();
      if (accepted) idx++;
    end
    check("stream_all_accepted", (idx == 3), 1'b1);
    pi_valid = 1'b0;
    ticks(25);

    // Accept on the last-bit cycle with an empty hold buffer.
    pi_valid = 1'b1;
    pi_data  = W'($urandom);
    tick();
    pi_valid = 1'b0;
    ticks(6);
    pi_valid = 1'b1;
    pi_data  = 7'h40;
    tick();
    pi_valid = 1'b0;
    ticks(10);

    // Reset while mid-word with a held word pending.
    pi_valid = 1'b1;
    pi_data  = W'($urandom);
    tick();
    pi_data  = W'($urandom);
    tick();
    pi_valid = 1'b0;
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(12);

    // Back-pressure: data keeps changing while not ready; only accepted words may appear.
    for (int n = 0; n < 300; n++) begin
      pi_valid = ($urandom_range(0, 7) != 0);
      pi_data  = W'($urandom);
      tick();
    end
    pi_valid = 1'b0;
    ticks(20);

    // Random mix including occasional resets.
    for (int n = 0; n < 300; n++) begin
      rst      = ($urandom_range(0, 40) == 0);
      pi_valid = $urandom_range(0, 1) == 1;
      pi_data  = W'($urandom);
      tick();
    end
    rst      = 1'b0;
    pi_valid = 1'b0;
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
